// File: rtl/prog_timer.sv
// Runtime-programmable interval timer: one-shot / periodic, pause, tick pulse, saturating expiry count.
// Latency: all outputs registered; with period P the first expiry lands P+1 edges after enable rises.
// Backpressure: none; pause freezes all timing state, enable low clears it, load is always accepted.
module prog_timer #(
  parameter int WIDTH          = 24,
  parameter int DEFAULT_PERIOD = 10000,
  parameter int EXP_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pause,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             tick,
  output logic [EXP_W-1:0] expirations,
  output logic [WIDTH-1:0] period
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(DEFAULT_PERIOD);
  localparam logic [EXP_W-1:0] EXP_MAX    = '1;

  state_t state;

  // Period register: loads are honoured whenever reset is low, even when disabled or paused,
  // so a new period only takes part in the comparison from the following edge onwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= PERIOD_RST;
    end else if (load) begin
      period <= period_in;
    end
  end

  // Timer FSM with registered count, done, tick and saturating expiry counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      done        <= 1'b0;
      tick        <= 1'b0;
      expirations <= '0;
    end else begin
      tick <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        count       <= '0;
        done        <= 1'b0;
        expirations <= '0;
      end else if (!pause) begin
        case (state)
          // IDLE counts on the same edge it leaves, so it shares the RUN behaviour.
          IDLE, RUN: begin
            if (count >= period) begin
              tick <= 1'b1;
              if (expirations != EXP_MAX) begin
                expirations <= expirations + 1'b1;
              end
              if (!mode) begin
                done  <= 1'b1;
                state <= EXPIRED;
              end else begin
                count <= '0;
                state <= RUN;
              end
            end else begin
              // Cannot overflow: count only advances while strictly below period.
              count <= count + 1'b1;
              state <= RUN;
            end
          end
          EXPIRED: begin
            // Switching to periodic while expired restarts the interval from zero.
            if (mode) begin
              count <= '0;
              done  <= 1'b0;
              state <= RUN;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: a behavioural model queues the expected outputs of every edge,
// and a monitor pops and compares them after each edge. Directed scenarios are followed by random traffic.
// Two instances share the stimulus; the second uses a 2-bit expiry counter to exercise saturation.
module tb_prog_timer;
  localparam int W = 24;
  localparam int DEF_P = 10000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         pause = 1'b0;
  logic         mode = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] period_in = '0;

  logic [W-1:0] count, period, count_s, period_s;
  logic         done, tick, done_s, tick_s;
  logic [7:0]   expirations;
  logic [1:0]   expirations_s;

  always #5 clk = ~clk;

  prog_timer #(.WIDTH(W), .DEFAULT_PERIOD(DEF_P), .EXP_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .mode(mode), .load(load),
    .period_in(period_in), .count(count), .done(done), .tick(tick),
    .expirations(expirations), .period(period)
  );

  prog_timer #(.WIDTH(W), .DEFAULT_PERIOD(DEF_P), .EXP_W(2)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .mode(mode), .load(load),
    .period_in(period_in), .count(count_s), .done(done_s), .tick(tick_s),
    .expirations(expirations_s), .period(period_s)
  );

  typedef struct {
    int count;
    bit done;
    bit tick;
    int exp;
    int period;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model: an unbounded expiry tally (saturated only when compared) and a
  // flag recording that a one-shot interval has finished and is waiting.
  int m_count = 0;
  int m_exp = 0;
  int m_period = DEF_P;
  bit m_done = 0;
  bit m_tick = 0;
  bit m_finished = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit p, input bit m, input bit l,
                            input int pi);
    exp_t x;
    m_tick = 0;
    if (r) begin
      m_count = 0; m_done = 0; m_exp = 0; m_finished = 0; m_period = DEF_P;
    end else begin
      if (!e) begin
        m_count = 0; m_done = 0; m_exp = 0; m_finished = 0;
      end else if (!p) begin
        if (m_finished) begin
          if (m) begin
            m_finished = 0; m_done = 0; m_count = 0;
          end
        end else if (m_count >= m_period) begin
          m_tick = 1;
          m_exp++;
          if (m) m_count = 0;
          else begin
            m_done = 1; m_finished = 1;
          end
        end else begin
          m_count++;
        end
      end
      if (l) m_period = pi;
    end
    x.count = m_count; x.done = m_done; x.tick = m_tick; x.exp = m_exp; x.period = m_period;
    sb.push_back(x);
  endtask

  // Drive one cycle of inputs away from the active edge and queue the expected post-edge outputs.
  task automatic cyc(input bit r, input bit e, input bit p, input bit m, input bit l, input int pi);
    @(negedge clk);
    reset = r; enable = e; pause = p; mode = m; load = l; period_in = W'(pi);
    model_edge(r, e, p, m, l, pi);
  endtask

  // One non-reset cycle, returning tick and done as seen just after the edge.
  task automatic step(input bit e, input bit p, input bit m, input bit l, input int pi,
                      output bit tk, output bit dn);
    cyc(1'b0, e, p, m, l, pi);
    @(posedge clk);
    #1;
    tk = tick;
    dn = done;
  endtask

  // Monitor: compare every edge for which the stimulus queued an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count", count, e.count);
        chk("done", done, e.done);
        chk("tick", tick, e.tick);
        chk("expirations", expirations, (e.exp > 255) ? 255 : e.exp);
        chk("period", period, e.period);
        chk("tick_sat_inst", tick_s, e.tick);
        chk("expirations_sat", expirations_s, (e.exp > 3) ? 3 : e.exp);
      end
    end
  end

  initial begin
    bit tk, dn;
    int first;
    int tl[$];
    int want[$];

    // Reset for two cycles: all outputs zero, default period.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // One-shot at the default period: done and tick rise at edge 10001.
    first = 0;
    tl.delete();
    for (int n = 1; n <= 10004; n++) begin
      step(1, 0, 0, 0, 0, tk, dn);
      if (dn && first == 0) first = n;
      if (tk) tl.push_back(n);
    end
    chk("oneshot_done_edge", first, 10001);
    chk("oneshot_tick_count", tl.size(), 1);
    chk("oneshot_done_sticky", dn, 1);
    chk("oneshot_count_hold", count, 10000);

    // Periodic with P = 4 loaded while disabled: ticks at edges 5, 10, 15, 20.
    step(0, 0, 1, 1, 4, tk, dn);
    tl.delete();
    for (int n = 1; n <= 20; n++) begin
      step(1, 0, 1, 0, 0, tk, dn);
      if (tk) tl.push_back(n);
    end
    want = '{5, 10, 15, 20};
    chk("periodic_tick_count", tl.size(), 4);
    foreach (want[i]) if (i < tl.size()) chk("periodic_tick_edge", tl[i], want[i]);
    chk("periodic_expirations", expirations, 4);

    // Pause for 3 cycles at count 5 with P = 9: done moves from edge 10 to edge 13.
    step(0, 0, 0, 1, 9, tk, dn);
    first = 0;
    for (int n = 1; n <= 16; n++) begin
      step(1, (n >= 6 && n <= 8), 0, 0, 0, tk, dn);
      if (dn && first == 0) first = n;
    end
    chk("pause_done_edge", first, 13);
    step(0, 0, 0, 0, 0, tk, dn);
    chk("enable_drop_count", count, 0);
    chk("enable_drop_done", done, 0);
    chk("enable_drop_exp", expirations, 0);
    chk("enable_drop_keeps_period", period, 9);

    // Load 10 while counting towards 100 at count 50: tick on edge 52, then every 11 cycles.
    step(0, 0, 1, 1, 100, tk, dn);
    tl.delete();
    for (int n = 1; n <= 80; n++) begin
      step(1, 0, 1, (n == 51), 10, tk, dn);
      if (tk) tl.push_back(n);
    end
    want = '{52, 63, 74};
    chk("load_below_tick_count", tl.size(), 3);
    foreach (want[i]) if (i < tl.size()) chk("load_below_tick_edge", tl[i], want[i]);

    // P = 0 periodic: tick every cycle, 2-bit expiry counter saturates at 3.
    step(0, 0, 1, 1, 0, tk, dn);
    want = '{1, 2, 3, 3, 3};
    foreach (want[i]) begin
      step(1, 0, 1, 0, 0, tk, dn);
      chk("p0_tick", tk, 1);
      chk("p0_count", count, 0);
      chk("p0_exp_sat", expirations_s, want[i]);
    end

    // One-shot expires at edge 4 with P = 3, then mode goes periodic at edge 6.
    step(0, 0, 0, 1, 3, tk, dn);
    first = 0;
    for (int n = 1; n <= 12; n++) begin
      step(1, 0, (n >= 6), 0, 0, tk, dn);
      if (n == 4) chk("mode_sw_done_edge", dn, 1);
      if (n == 6) begin
        chk("mode_sw_done_clear", dn, 0);
        chk("mode_sw_count_clear", count, 0);
      end
      if (n > 6 && tk && first == 0) first = n;
    end
    chk("mode_sw_next_tick", first, 10);

    // Random traffic: occasional reset, enable drops, pauses, loads and mode flips.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom % 100) == 0, ($urandom % 20) != 0, ($urandom % 8) == 0,
          1'($urandom % 2), ($urandom % 16) == 0, int'($urandom % 12));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
